// File: rtl/cacheline_pkg.sv
// Shared types and constants for the cacheline-to-burst adapter.
// Splits a 256-bit line into four 64-bit beats.
package cacheline_pkg;

    localparam int unsigned CL_ADDR_W   = 32;
    localparam int unsigned CL_BEAT_W   = 64;
    localparam int unsigned CL_BEATS    = 4;
    localparam int unsigned CL_LINE_W   = CL_BEAT_W * CL_BEATS;
    localparam int unsigned CL_OFFSET_W = $clog2(CL_LINE_W / 8);

    // Byte-offset bits within a line; cleared to form the burst address.
    localparam logic [CL_ADDR_W-1:0] CL_OFFSET_MASK = CL_ADDR_W'((64'd1 << CL_OFFSET_W) - 64'd1);

    typedef logic [CL_LINE_W-1:0] line_t;
    typedef logic [CL_BEAT_W-1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [CL_ADDR_W-1:0] align_line_addr(input logic [CL_ADDR_W-1:0] addr);
        return addr & ~CL_OFFSET_MASK;
    endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Line storage for the adapter: assembles read beats into a line, holds the
// write line for beat slicing, and owns the beat counter.
module line_beat_buffer #(
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned BEATS  = 4,
    parameter int unsigned CNT_W  = $clog2(BEATS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cnt_clr_i,
    input  logic                      cnt_inc_i,
    output logic [CNT_W-1:0]          cnt_o,
    input  logic                      line_load_i,
    input  logic [BEAT_W*BEATS-1:0]   line_wdata_i,
    input  logic                      beat_we_i,
    input  logic [BEAT_W-1:0]         beat_wdata_i,
    input  logic [CNT_W-1:0]          beat_sel_i,
    output logic [BEAT_W-1:0]         sel_beat_c_o,
    output logic [BEAT_W*BEATS-1:0]   rd_line_o
);

    localparam int unsigned LINE_W = BEAT_W * BEATS;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] rd_line_q, rd_line_d;
    logic [LINE_W-1:0] wr_line_q, wr_line_d;

    // Counter: cleared at acceptance, advanced by the adapter on accepted beats.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (cnt_inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Read assembly stores the incoming beat at the current counter slot.
    always_comb begin
        rd_line_d = rd_line_q;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (beat_we_i && (cnt_q == CNT_W'(k))) begin
                rd_line_d[k*BEAT_W +: BEAT_W] = beat_wdata_i;
            end
        end
    end

    always_comb begin
        wr_line_d = wr_line_q;
        if (line_load_i) begin
            wr_line_d = line_wdata_i;
        end
    end

    // Beat slice of the latched write line selected by beat_sel_i.
    always_comb begin
        sel_beat_c_o = '0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (beat_sel_i == CNT_W'(k)) begin
                sel_beat_c_o = wr_line_q[k*BEAT_W +: BEAT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rd_line_q <= '0;
            wr_line_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            rd_line_q <= rd_line_d;
            wr_line_q <= wr_line_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign rd_line_o = rd_line_q;

endmodule

// File: rtl/cacheline_adapter.sv
// Serves one cacheline read/write from an L1 cache as a fixed multi-beat
// burst on the memory port; all outputs are registered.
module cacheline_adapter
    import cacheline_pkg::*;
#(
    parameter int unsigned ADDR_W = CL_ADDR_W,
    parameter int unsigned BEAT_W = CL_BEAT_W,
    parameter int unsigned BEATS  = CL_BEATS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     line_read,
    input  logic                     line_write,
    input  logic [ADDR_W-1:0]        line_addr,
    input  logic [BEAT_W*BEATS-1:0]  line_wdata,
    output logic [BEAT_W*BEATS-1:0]  line_rdata,
    output logic                     line_resp,
    output logic                     burst_read,
    output logic                     burst_write,
    output logic [ADDR_W-1:0]        burst_addr,
    output logic [BEAT_W-1:0]        burst_wdata,
    input  logic [BEAT_W-1:0]        burst_rdata,
    input  logic                     burst_resp
);

    localparam int unsigned LINE_W = BEAT_W * BEATS;
    localparam int unsigned CNT_W  = $clog2(BEATS);
    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  next_sel;
    logic [BEAT_W-1:0] next_beat;
    logic [LINE_W-1:0] rd_line;
    logic              last_beat;
    logic              accept;
    logic              wr_load;
    logic              rd_we;
    logic              cnt_clr;
    logic              cnt_inc;

    logic              line_resp_q,   line_resp_d;
    logic              burst_read_q,  burst_read_d;
    logic              burst_write_q, burst_write_d;
    logic [ADDR_W-1:0] burst_addr_q,  burst_addr_d;
    logic [BEAT_W-1:0] burst_wdata_q, burst_wdata_d;

    assign last_beat = (cnt == LAST_BEAT);

    line_beat_buffer #(
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS),
        .CNT_W  (CNT_W)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .cnt_clr_i    (cnt_clr),
        .cnt_inc_i    (cnt_inc),
        .cnt_o        (cnt),
        .line_load_i  (wr_load),
        .line_wdata_i (line_wdata),
        .beat_we_i    (rd_we),
        .beat_wdata_i (burst_rdata),
        .beat_sel_i   (next_sel),
        .sel_beat_c_o (next_beat),
        .rd_line_o    (rd_line)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: write wins a simultaneous request; the last accepted beat ends the burst.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (line_write) begin
                    state_d = WRITE;
                end else if (line_read) begin
                    state_d = READ;
                end
            end
            READ, WRITE: begin
                if (burst_resp && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and buffer control: outputs are computed one cycle ahead and registered.
    always_comb begin
        accept        = (state_q == IDLE) && (line_read || line_write);
        wr_load       = (state_q == IDLE) && line_write;
        rd_we         = (state_q == READ) && burst_resp;
        cnt_clr       = accept;
        cnt_inc       = ((state_q == READ) || (state_q == WRITE)) && burst_resp && !last_beat;
        next_sel      = cnt + CNT_W'(1);
        burst_read_d  = (state_d == READ);
        burst_write_d = (state_d == WRITE);
        line_resp_d   = (state_d == DONE);
        burst_addr_d  = accept ? (line_addr & ~OFF_MASK) : burst_addr_q;
        burst_wdata_d = burst_wdata_q;
        if (wr_load) begin
            burst_wdata_d = line_wdata[BEAT_W-1:0];
        end else if ((state_q == WRITE) && burst_resp && !last_beat) begin
            burst_wdata_d = next_beat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_resp_q   <= 1'b0;
            burst_read_q  <= 1'b0;
            burst_write_q <= 1'b0;
            burst_addr_q  <= '0;
            burst_wdata_q <= '0;
        end else begin
            line_resp_q   <= line_resp_d;
            burst_read_q  <= burst_read_d;
            burst_write_q <= burst_write_d;
            burst_addr_q  <= burst_addr_d;
            burst_wdata_q <= burst_wdata_d;
        end
    end

    assign line_rdata  = rd_line;
    assign line_resp   = line_resp_q;
    assign burst_read  = burst_read_q;
    assign burst_write = burst_write_q;
    assign burst_addr  = burst_addr_q;
    assign burst_wdata = burst_wdata_q;

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Responder on the cache's line-side interface: accepts one 256-bit cacheline read or write from an L1 cache and serves it as a fixed 4-beat x 64-bit burst to physical memory.
- Sits between the cache's upper-side port (read/write/addr/rdata/wdata/resp) and the burst memory port.
- Assembles incoming beats into a line for reads and slices the line into beats for writes.
- Returns a single-cycle line response when the burst completes.

Parameters:
- ADDR_W, 32, byte-address width on both sides
- BEAT_W, 64, burst data width per beat
- BEATS, 4, beats per line; LINE_W = BEAT_W*BEATS = 256 (derived, not overridable)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- line_read  in  1  line read request from cache; held until line_resp
- line_write  in  1  line write request from cache; held until line_resp
- line_addr  in  ADDR_W  line address; low 5 bits ignored
- line_wdata  in  LINE_W  write line; sampled at request acceptance
- line_rdata  out  LINE_W  assembled read line
- line_resp  out  1  one-cycle completion pulse
- burst_read  out  1  burst read request to memory
- burst_write  out  1  burst write request to memory
- burst_addr  out  ADDR_W  line-aligned burst address ({addr[31:5],5'b0})
- burst_wdata  out  BEAT_W  current write beat
- burst_rdata  in  BEAT_W  current read beat
- burst_resp  in  1  beat accepted/valid this cycle

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat counter=0, line_resp=0, burst_read=0, burst_write=0, burst_addr=0, burst_wdata=0, line_rdata=0.
- All outputs are registered; no combinational path from any input to any output.
- States:
  - IDLE: line_write -> WRITE; else line_read -> READ. Write has priority if both are high.
  - On acceptance: latch aligned address and line_wdata; clear beat counter.
  - READ: burst_read=1.
  - WRITE: burst_write=1; burst_wdata = latched line bits [64k+63:64k], k = beat counter.
  - READ/WRITE: each cycle with burst_resp=1 advances the counter.
    - READ also stores burst_rdata into line_rdata[64k+63:64k] on that beat.
    - On the beat with k=BEATS-1 -> DONE. burst_read/burst_write deassert on that edge.
  - DONE: line_resp=1 for exactly one cycle -> IDLE unconditionally.
- line_rdata holds its value from DONE until the next READ overwrites beat 0.
- burst_addr is held constant for the whole burst; no per-beat increment (memory sequences beats).
- Zero-wait latency: request seen in cycle 0, burst request in cycle 1, beats in cycles 1-4, line_resp in cycle 5.
- Wait states: any number of cycles with burst_resp=0 simply stall the counter.
- Boundary conditions:
  - Counter is 2 bits and never wraps within a request.
  - burst_resp in IDLE or DONE is ignored.
  - line_read/line_write changes during a burst are ignored; the operation is fixed at acceptance.
  - The initiator deasserts its request on the edge after line_resp, so IDLE never re-accepts a completed request.
  - Reset mid-burst aborts immediately: outputs go to reset values, and subsequent stray burst_resp beats are ignored.

Decomposition:
- Package cacheline_pkg: state enum (IDLE, READ, WRITE, DONE), BEAT_W/BEATS/LINE_W constants, line_t (256-bit) and beat_t (64-bit) typedefs, offset-mask constant.
- One sub-module, line_beat_buffer: 256-bit register with a beat-indexed write port (read assembly) and a beat-indexed read mux (write slicing), plus the 2-bit counter.

Test Plan:
- Read, zero-wait memory returning beats 64'h0..0, ..01, ..02, ..03 at line_addr 32'h0000_0047 -> burst_addr 32'h0000_0040; line_resp in cycle 5; line_rdata = {..03, ..02, ..01, ..00}.
- Write of line 256'h(DDDD..CCCC..BBBB..AAAA) with burst_resp high 1 cycle in 3 -> burst_wdata sequence AAAA, BBBB, CCCC, DDDD, each held until its resp; line_resp exactly once.
- line_read and line_write both high in IDLE -> burst_write=1, burst_read stays 0.
- Back-to-back reads to 32'h20 then 32'h40 -> second burst_read starts the cycle after IDLE is re-entered; first line_rdata is stable until the second read's beat 0.
- rst_n low during beat 2 of a read, with memory then pulsing burst_resp twice -> all outputs 0; state IDLE; no line_resp; stray beats ignored.
- burst_resp asserted in IDLE with no request -> no state change, line_rdata unchanged.
